sdram_rw_sched: RTL and testbench
=================================

SDRAM_RW_SCHED -- requirements
Module: sdram_rw_sched

Interface
REQ-001 clk  input  1  scheduler clock; same 100 MHz domain as the SDRAM controller core.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 sdram_init_done  input  1  SDRAM power-up initialisation complete.
REQ-004 wr_fifo_cnt  input  10  words currently held in the write-port FIFO, already synchronised to clk.
REQ-005 rd_fifo_cnt  input  10  words currently held in the read-port FIFO, already synchronised to clk.
REQ-006 wr_len, rd_len  input  10 each  burst length in words; legal range 1..512.
REQ-007 wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr  input  24 each  region bounds in words; min is inclusive, max is exclusive.
REQ-008 wr_load, rd_load  input  1 each  level-sensitive port reload, synchronous to clk.
REQ-009 sdram_read_valid  input  1  read port enabled.
REQ-010 sdram_pingpang_en  input  1  two-bank ping-pong enabled.
REQ-011 sdram_wr_req, sdram_rd_req  output  1 each  burst request to the controller core.
REQ-012 sdram_wr_addr, sdram_rd_addr  output  24 each  burst start address.
REQ-013 sdram_wr_burst, sdram_rd_burst  output  10 each  burst length.
REQ-014 sdram_wr_done, sdram_rd_done  input  1 each  one-cycle pulse when the core finishes a burst.

Function
REQ-015 The FSM has three states, IDLE, WR and RD, and shall remain in IDLE while sdram_init_done=0.
REQ-016 Write eligibility is wr_fifo_cnt>=wr_len; read eligibility is sdram_read_valid=1 and rd_fifo_cnt<rd_len.
REQ-017 In IDLE, when exactly one port is eligible, the FSM shall go to that port's state; when both are eligible, it shall grant the port not granted last (last_grant resets to RD, so write wins first).
REQ-018 The request output shall be registered and assert on the cycle after the IDLE sample; address and burst outputs shall be captured at grant and held stable while the request is high.
REQ-019 A request shall stay high until its done pulse; on the done cycle the request drops and the FSM returns to IDLE, giving a minimum of 1 idle cycle between bursts.
REQ-020 A done pulse for the port not currently granted shall be ignored.
REQ-021 Address advance on done: if addr+len<max, then addr=addr+len; otherwise addr=min (wrap), computed with 25-bit compare to avoid overflow.
REQ-022 On a write wrap with pingpang_en=1, wr_bank toggles.
REQ-023 On a read wrap with pingpang_en=1, rd_bank is set to ~wr_bank, so the read always uses the bank not being written.
REQ-024 Output address is {bank, addr[22:0]} when pingpang_en=1, and addr unchanged when pingpang_en=0; banks do not change while pingpang_en=0.
REQ-025 A load assertion sets that port's addr=min and bank to its reset value, taking effect the next cycle.
REQ-026 A load during an active burst does not drop the request; the burst completes, and load has priority over the done-increment in the same cycle.
REQ-027 sdram_init_done falling mid-burst shall not abort the burst; no new grants are made until it returns high.

Reset
REQ-028 On rst_n=0: state=IDLE; all req=0; all addr/burst outputs=0; internal addresses=0; wr_bank=0; rd_bank=1; last_grant=RD.

Structure
REQ-029 A shared package sdram_sched_pkg shall hold the state encoding, ADDR_W=24, LEN_W=10 and the grant-select type.
REQ-030 A sub-module sdram_addr_gen (address register, wrap, bank, load) shall be instantiated once per port.

Verification
REQ-031 Basic write: wr_len=512, wr_fifo_cnt=512, rd_fifo_cnt=600 -> sdram_wr_req high 1 cycle later, addr=0, burst=512; after done -> next addr=512.
REQ-032 Both ports continuously eligible -> grants alternate WR,RD,WR,RD; each request is held until its done pulse.
REQ-033 Write wrap: max=307200, len=512, pingpang=1 -> the 600th done wraps addr to 0 and wr_bank goes 0->1; the next sdram_wr_addr=0x800000; the next read wrap gives rd_bank=0.
REQ-034 pingpang_en=0 through several wraps -> bit23 of the address is always 0 and the banks stay at their reset values.
REQ-035 wr_load pulsed mid-burst at addr=1024 -> the request remains until done; the next write addr=wr_min_addr, not 1536.
REQ-036 sdram_init_done=0 with both ports eligible -> no request for 1000 cycles; rst_n asserted mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sdram_sched_pkg.sv
// Shared types and widths for the SDRAM read/write burst scheduler.
package sdram_sched_pkg;
    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } sched_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    // In ping-pong mode the bank bit replaces the top address bit.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic pp, input logic bank,
                                                    input logic [ADDR_W-1:0] a);
        return pp ? {bank, a[ADDR_W-2:0]} : a;
    endfunction
endpackage

// File: rtl/sdram_addr_gen.sv
// Per-port burst address pointer: region wrap, ping-pong bank, reload.
// Latency: advance/load visible one cycle after the qualifying edge.
// Backpressure: none; advances only on the scheduler's qualified done.
module sdram_addr_gen
    import sdram_sched_pkg::*;
#(
    parameter logic BANK_RST    = 1'b0,
    parameter bit   FOLLOW_PEER = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pingpang_en,
    input  logic              load,
    input  logic              busy,
    input  logic              advance,
    input  logic [ADDR_W-1:0] min_addr,
    input  logic [ADDR_W-1:0] max_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              peer_bank,
    output logic              bank,
    output logic [ADDR_W-1:0] out_addr
);
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   next_sum;
    logic              wrap;
    logic              skip_adv;

    assign next_sum = {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
    assign wrap     = next_sum >= {1'b0, max_addr};

    // A reload during a burst makes that burst's done stale: the pointer must
    // stay at min instead of advancing past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            bank     <= BANK_RST;
            skip_adv <= 1'b0;
        end else if (load) begin
            addr     <= min_addr;
            bank     <= BANK_RST;
            skip_adv <= busy && !advance;
        end else if (advance) begin
            skip_adv <= 1'b0;
            if (!skip_adv) begin
                addr <= wrap ? min_addr : next_sum[ADDR_W-1:0];
                if (wrap && pingpang_en)
                    bank <= FOLLOW_PEER ? ~peer_bank : ~bank;
            end
        end
    end

    assign out_addr = bank_addr(pingpang_en, bank, addr);
endmodule

// File: rtl/sdram_rw_sched.sv
// Arbitrates write/read burst requests to the SDRAM controller core.
// Latency: request registered, high one cycle after the IDLE grant sample.
// Backpressure: request held until the core's done pulse; FIFO levels gate grants.
module sdram_rw_sched
    import sdram_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [LEN_W-1:0]  wr_fifo_cnt,
    input  logic [LEN_W-1:0]  rd_fifo_cnt,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic [ADDR_W-1:0] wr_min_addr,
    input  logic [ADDR_W-1:0] wr_max_addr,
    input  logic [ADDR_W-1:0] rd_min_addr,
    input  logic [ADDR_W-1:0] rd_max_addr,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              sdram_read_valid,
    input  logic              sdram_pingpang_en,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [LEN_W-1:0]  sdram_wr_burst,
    output logic [LEN_W-1:0]  sdram_rd_burst,
    input  logic              sdram_wr_done,
    input  logic              sdram_rd_done
);
    sched_state_t      state;
    grant_t            last_grant;
    logic              wr_elig, rd_elig;
    logic              wr_busy, rd_busy;
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_gen_addr, rd_gen_addr;

    assign wr_elig = wr_fifo_cnt >= wr_len;
    assign rd_elig = sdram_read_valid && (rd_fifo_cnt < rd_len);
    assign wr_busy = state == ST_WR;
    assign rd_busy = state == ST_RD;

    sdram_addr_gen #(.BANK_RST(1'b0), .FOLLOW_PEER(1'b0)) u_wr_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .pingpang_en (sdram_pingpang_en),
        .load        (wr_load),
        .busy        (wr_busy),
        .advance     (wr_busy && sdram_wr_done),
        .min_addr    (wr_min_addr),
        .max_addr    (wr_max_addr),
        .len         (wr_len),
        .peer_bank   (rd_bank),
        .bank        (wr_bank),
        .out_addr    (wr_gen_addr)
    );

    // The read bank follows the writer so reads always hit the bank not being filled.
    sdram_addr_gen #(.BANK_RST(1'b1), .FOLLOW_PEER(1'b1)) u_rd_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .pingpang_en (sdram_pingpang_en),
        .load        (rd_load),
        .busy        (rd_busy),
        .advance     (rd_busy && sdram_rd_done),
        .min_addr    (rd_min_addr),
        .max_addr    (rd_max_addr),
        .len         (rd_len),
        .peer_bank   (wr_bank),
        .bank        (rd_bank),
        .out_addr    (rd_gen_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_grant     <= GNT_RD;
            sdram_wr_req   <= 1'b0;
            sdram_rd_req   <= 1'b0;
            sdram_wr_addr  <= '0;
            sdram_rd_addr  <= '0;
            sdram_wr_burst <= '0;
            sdram_rd_burst <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sdram_init_done) begin
                        if (wr_elig && (!rd_elig || last_grant == GNT_RD)) begin
                            state          <= ST_WR;
                            last_grant     <= GNT_WR;
                            sdram_wr_req   <= 1'b1;
                            sdram_wr_addr  <= wr_gen_addr;
                            sdram_wr_burst <= wr_len;
                        end else if (rd_elig) begin
                            state          <= ST_RD;
                            last_grant     <= GNT_RD;
                            sdram_rd_req   <= 1'b1;
                            sdram_rd_addr  <= rd_gen_addr;
                            sdram_rd_burst <= rd_len;
                        end
                    end
                end
                ST_WR: begin
                    if (sdram_wr_done) begin
                        state        <= ST_IDLE;
                        sdram_wr_req <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (sdram_rd_done) begin
                        state        <= ST_IDLE;
                        sdram_rd_req <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    sdram_wr_req <= 1'b0;
                    sdram_rd_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_rw_sched.sv
// Directed bench for sdram_rw_sched with a burst scoreboard and a done responder.
module tb_sdram_rw_sched;
    logic        clk;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_cnt, rd_fifo_cnt;
    logic [9:0]  wr_len, rd_len;
    logic [23:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
    logic        wr_load, rd_load;
    logic        sdram_read_valid, sdram_pingpang_en;
    logic        sdram_wr_req, sdram_rd_req;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic        sdram_wr_done, sdram_rd_done;

    typedef struct {
        logic        rd;
        logic [23:0] addr;
        logic [9:0]  burst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    sdram_rw_sched dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sdram_init_done   (sdram_init_done),
        .wr_fifo_cnt       (wr_fifo_cnt),
        .rd_fifo_cnt       (rd_fifo_cnt),
        .wr_len            (wr_len),
        .rd_len            (rd_len),
        .wr_min_addr       (wr_min_addr),
        .wr_max_addr       (wr_max_addr),
        .rd_min_addr       (rd_min_addr),
        .rd_max_addr       (rd_max_addr),
        .wr_load           (wr_load),
        .rd_load           (rd_load),
        .sdram_read_valid  (sdram_read_valid),
        .sdram_pingpang_en (sdram_pingpang_en),
        .sdram_wr_req      (sdram_wr_req),
        .sdram_rd_req      (sdram_rd_req),
        .sdram_wr_addr     (sdram_wr_addr),
        .sdram_rd_addr     (sdram_rd_addr),
        .sdram_wr_burst    (sdram_wr_burst),
        .sdram_rd_burst    (sdram_rd_burst),
        .sdram_wr_done     (sdram_wr_done),
        .sdram_rd_done     (sdram_rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_burst(input logic rd, input logic [23:0] a, input logic [9:0] b);
        exp_t e;
        e.rd = rd; e.addr = a; e.burst = b;
        sb.push_back(e);
    endtask

    task automatic clear_pulses();
        sdram_wr_done = 1'b0; sdram_rd_done = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0;
    endtask

    // Wait for a request, score it, hold it for 'hold' cycles, then complete it.
    // ld_mode: 0 none, 1 reload mid-burst, 2 reload on the done cycle.
    task automatic serve(input int hold, input int ld_mode, input bit stray, input bit drop_init);
        exp_t        e;
        bit          got = 0;
        bit          is_rd;
        logic [23:0] a0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) got = 1;
        end
        chk("req_seen", 32'(got), 32'd1);
        if (!got) return;
        is_rd = sdram_rd_req;
        if (sb.size() > 0) e = sb.pop_front();
        else begin e.rd = ~is_rd; e.addr = '1; e.burst = '0; end
        chk("one_req", 32'(sdram_wr_req & sdram_rd_req), 32'd0);
        chk("port", 32'(is_rd), 32'(e.rd));
        a0 = is_rd ? sdram_rd_addr : sdram_wr_addr;
        chk("addr", 32'(a0), 32'(e.addr));
        chk("burst", 32'(is_rd ? sdram_rd_burst : sdram_wr_burst), 32'(e.burst));
        for (int i = 0; i < hold; i++) begin
            if (stray && i == 0) begin
                if (is_rd) sdram_wr_done = 1'b1; else sdram_rd_done = 1'b1;
            end
            if (ld_mode == 1 && i == 1) begin
                if (is_rd) rd_load = 1'b1; else wr_load = 1'b1;
            end
            if (drop_init && i == 0) sdram_init_done = 1'b0;
            @(negedge clk);
            clear_pulses();
        end
        chk("req_held", 32'(is_rd ? sdram_rd_req : sdram_wr_req), 32'd1);
        chk("addr_held", 32'(is_rd ? sdram_rd_addr : sdram_wr_addr), 32'(a0));
        if (is_rd) sdram_rd_done = 1'b1; else sdram_wr_done = 1'b1;
        if (ld_mode == 2) begin
            if (is_rd) rd_load = 1'b1; else wr_load = 1'b1;
        end
        @(negedge clk);
        clear_pulses();
        chk("req_drop", 32'(is_rd ? sdram_rd_req : sdram_wr_req), 32'd0);
    endtask

    task automatic pulse_loads();
        wr_load = 1'b1; rd_load = 1'b1;
        @(negedge clk);
        clear_pulses();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_req"}, 32'(sdram_wr_req), 32'd0);
        chk({tag, "_rd_req"}, 32'(sdram_rd_req), 32'd0);
        chk({tag, "_wr_addr"}, 32'(sdram_wr_addr), 32'd0);
        chk({tag, "_rd_addr"}, 32'(sdram_rd_addr), 32'd0);
        chk({tag, "_wr_burst"}, 32'(sdram_wr_burst), 32'd0);
        chk({tag, "_rd_burst"}, 32'(sdram_rd_burst), 32'd0);
    endtask

    initial begin
        int bad;
        bit got;
        rst_n = 1'b0; sdram_init_done = 1'b0;
        wr_fifo_cnt = '0; rd_fifo_cnt = '0; wr_len = 10'd512; rd_len = 10'd512;
        wr_min_addr = '0; wr_max_addr = 24'd307200; rd_min_addr = '0; rd_max_addr = 24'd307200;
        sdram_read_valid = 1'b0; sdram_pingpang_en = 1'b0;
        clear_pulses();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Both ports eligible but init not done: no requests at all
        wr_fifo_cnt = 10'd512; rd_fifo_cnt = 10'd0; sdram_read_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) bad++;
        end
        chk("no_req_before_init", 32'(bad), 32'd0);

        // Basic write: request one cycle after the grant sample, then next address
        rd_fifo_cnt = 10'd600;
        sdram_init_done = 1'b1;
        @(negedge clk);
        chk("wr_req_one_cycle", 32'(sdram_wr_req), 32'd1);
        expect_burst(1'b0, 24'd0, 10'd512);
        serve(2, 0, 0, 0);
        expect_burst(1'b0, 24'd512, 10'd512);
        serve(2, 0, 0, 0);

        // Both eligible: alternate, stray done ignored, reloads
        rd_fifo_cnt = 10'd0; wr_min_addr = 24'd4096;
        expect_burst(1'b1, 24'd0, 10'd512);    serve(2, 0, 0, 0);
        expect_burst(1'b0, 24'd1024, 10'd512); serve(3, 1, 1, 0);
        expect_burst(1'b1, 24'd512, 10'd512);  serve(2, 0, 0, 0);
        expect_burst(1'b0, 24'd4096, 10'd512); serve(1, 2, 0, 0);
        expect_burst(1'b1, 24'd1024, 10'd512); serve(2, 0, 0, 0);
        expect_burst(1'b0, 24'd4096, 10'd512); serve(2, 0, 0, 0);
        wr_fifo_cnt = 10'd0; sdram_read_valid = 1'b0;

        // Ping-pong write wrap after 600 bursts, then read wrap follows the writer
        wr_min_addr = '0; wr_max_addr = 24'd307200; rd_max_addr = 24'd1024;
        sdram_pingpang_en = 1'b1;
        pulse_loads();
        wr_fifo_cnt = 10'd512;
        for (int k = 0; k < 600; k++) begin
            expect_burst(1'b0, 24'(k * 512), 10'd512);
            serve(0, 0, 0, 0);
        end
        expect_burst(1'b0, 24'h800000, 10'd512);
        serve(0, 0, 0, 0);
        wr_fifo_cnt = 10'd0; sdram_read_valid = 1'b1;
        expect_burst(1'b1, 24'h800000, 10'd512); serve(1, 0, 0, 0);
        expect_burst(1'b1, 24'h800200, 10'd512); serve(1, 0, 0, 0);
        expect_burst(1'b1, 24'h000000, 10'd512); serve(1, 0, 0, 0);
        sdram_read_valid = 1'b0;

        // No ping-pong across several wraps: bit 23 stays low, banks untouched
        sdram_pingpang_en = 1'b0; wr_max_addr = 24'd1024;
        pulse_loads();
        wr_fifo_cnt = 10'd512;
        for (int k = 0; k < 6; k++) begin
            expect_burst(1'b0, 24'((k % 2) * 512), 10'd512);
            serve(1, 0, 0, 0);
        end
        wr_fifo_cnt = 10'd0; sdram_read_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_burst(1'b1, 24'((k % 2) * 512), 10'd512);
            serve(1, 0, 0, 0);
        end
        sdram_read_valid = 1'b0; sdram_pingpang_en = 1'b1; wr_fifo_cnt = 10'd512;
        expect_burst(1'b0, 24'h000000, 10'd512); serve(1, 0, 0, 0);
        wr_fifo_cnt = 10'd0; sdram_read_valid = 1'b1;
        expect_burst(1'b1, 24'h800000, 10'd512); serve(1, 0, 0, 0);
        sdram_read_valid = 1'b0;

        // Init drop mid-burst completes the burst, then blocks new grants
        sdram_pingpang_en = 1'b0; wr_fifo_cnt = 10'd512;
        expect_burst(1'b0, 24'd512, 10'd512);
        serve(3, 0, 0, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req) bad++;
        end
        chk("no_grant_init_low", 32'(bad), 32'd0);

        // Asynchronous reset in the middle of a burst
        sdram_init_done = 1'b1;
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (sdram_wr_req) got = 1;
        end
        chk("req_after_init", 32'(got), 32'd1);
        chk("addr_after_wrap", 32'(sdram_wr_addr), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
